// File: rtl/mem_responder_if.sv
// Request/response bundle for the stall-based memory interface.
// The initiator drives the request side; the responder drives stall and the response.
interface mem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  stall, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output stall, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency memory responder backed by a quadword array.
// Holds stall for LATENCY cycles, then pulses rsp_valid with registered data/fault.
module mem_responder #(
    parameter int              WORDS   = 1024,
    parameter logic [63:0]     BASE    = 64'h0,
    parameter int              LATENCY = 3
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        load, do_access;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic [63:0] lat_addr, lat_wdata;
    logic        rsp_fault_q;
    logic [63:0] rsp_rdata_q;
    logic [63:0] mem [WORDS];

    // With LATENCY==1 the access happens at the accepting edge, so the live request is used.
    logic        use_live;
    logic        cur_we;
    logic [1:0]  cur_size;
    logic [63:0] cur_addr, cur_wdata;

    assign use_live  = (state_q == IDLE);
    assign cur_we    = use_live ? bus.req_we    : lat_we;
    assign cur_size  = use_live ? bus.req_size  : lat_size;
    assign cur_addr  = use_live ? bus.req_addr  : lat_addr;
    assign cur_wdata = use_live ? bus.req_wdata : lat_wdata;

    logic [63:0]     off;
    logic [60:0]     idx;
    logic [2:0]      lane;
    logic [IDXW-1:0] idx_t;
    logic            misaligned, fault;
    logic [7:0]      bmask;
    logic [63:0]     wsh, rd_shift, rd_val;

    assign off   = cur_addr - BASE;
    assign idx   = off[63:3];
    assign lane  = off[2:0];
    assign idx_t = idx[IDXW-1:0];

    always_comb begin
        misaligned = 1'b0;
        bmask      = 8'h00;
        rd_val     = 64'h0;
        rd_shift   = mem[idx_t] >> {lane, 3'b000};
        wsh        = cur_wdata << {lane, 3'b000};
        case (cur_size)
            2'd0: begin
                bmask  = 8'h01 << lane;
                rd_val = {56'h0, rd_shift[7:0]};
            end
            2'd1: begin
                misaligned = lane[0];
                bmask      = 8'h03 << lane;
                rd_val     = {48'h0, rd_shift[15:0]};
            end
            2'd2: begin
                misaligned = (lane[1:0] != 2'b00);
                bmask      = 8'h0F << lane;
                rd_val     = {32'h0, rd_shift[31:0]};
            end
            default: begin
                misaligned = (lane != 3'b000);
                bmask      = 8'hFF;
                rd_val     = rd_shift;
            end
        endcase
        fault = misaligned || (idx >= 61'(WORDS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            lat_we    <= 1'b0;
            lat_size  <= 2'd0;
            lat_addr  <= 64'h0;
            lat_wdata <= 64'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                lat_we    <= bus.req_we;
                lat_size  <= bus.req_size;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        do_access = 1'b0;
        bus.stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    bus.stall = 1'b1;
                    load      = 1'b1;
                    if (LATENCY == 1) begin
                        state_d   = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                bus.stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d   = RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Array has no reset; reset still blocks a write that would land on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && do_access && !fault && cur_we) begin
            for (int b = 0; b < 8; b++) begin
                if (bmask[b]) mem[idx_t][8*b +: 8] <= wsh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata_q <= 64'h0;
            rsp_fault_q <= 1'b0;
        end else if (do_access) begin
            rsp_fault_q <= fault;
            rsp_rdata_q <= (fault || cur_we) ? 64'h0 : rd_val;
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_fault = rsp_fault_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: dut_a (LATENCY=3, BASE=0), dut_b (LATENCY=1, high BASE).
module tb_mem_responder;
    localparam logic [63:0] BASE_B = 64'hFFFF_FFFF_FFFF_0000;

    typedef struct packed {
        logic [63:0] rdata;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = 64'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        cur_sel = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    exp_t qa[$];
    exp_t qb[$];

    mem_responder_if aif();
    mem_responder_if bif();

    assign aif.req_valid = valid_a;
    assign aif.req_we    = req_we;
    assign aif.req_size  = req_size;
    assign aif.req_addr  = req_addr;
    assign aif.req_wdata = req_wdata;
    assign bif.req_valid = valid_b;
    assign bif.req_we    = req_we;
    assign bif.req_size  = req_size;
    assign bif.req_addr  = req_addr;
    assign bif.req_wdata = req_wdata;

    mem_responder #(.WORDS(1024), .BASE(64'h0), .LATENCY(3)) dut_a (
        .clk(clk), .reset(reset), .bus(aif.slave)
    );
    mem_responder #(.WORDS(1024), .BASE(BASE_B), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bif.slave)
    );

    always #5 clk = ~clk;

    logic sel_stall, sel_rsp_valid;
    assign sel_stall     = cur_sel ? bif.stall     : aif.stall;
    assign sel_rsp_valid = cur_sel ? bif.rsp_valid : aif.rsp_valid;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitors: every response pulse pops the oldest expectation for that instance.
    always @(negedge clk) begin
        if (aif.rsp_valid === 1'b1) begin
            exp_t e;
            if (qa.size() == 0) begin
                checkOutput("a unexpected rsp_valid", 64'd1, 64'd0);
            end else begin
                e = qa.pop_front();
                checkOutput("a rsp_rdata", aif.rsp_rdata, e.rdata);
                checkOutput("a rsp_fault", {63'h0, aif.rsp_fault}, {63'h0, e.fault});
            end
        end
    end

    always @(negedge clk) begin
        if (bif.rsp_valid === 1'b1) begin
            exp_t e;
            if (qb.size() == 0) begin
                checkOutput("b unexpected rsp_valid", 64'd1, 64'd0);
            end else begin
                e = qb.pop_front();
                checkOutput("b rsp_rdata", bif.rsp_rdata, e.rdata);
                checkOutput("b rsp_fault", {63'h0, bif.rsp_fault}, {63'h0, e.fault});
            end
        end
    end

    task automatic applyStimulus(input logic sel, input logic we, input logic [1:0] size,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] exp_rdata, input logic exp_fault);
        int  n;
        bit  got;
        int  lat;
        lat = sel ? 1 : 3;
        @(posedge clk);
        #1;
        cur_sel   = sel;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        if (sel) begin
            valid_b = 1'b1;
            qb.push_back('{rdata: exp_rdata, fault: exp_fault});
        end else begin
            valid_a = 1'b1;
            qa.push_back('{rdata: exp_rdata, fault: exp_fault});
        end
        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (sel_rsp_valid) begin
                got = 1'b1;
                checkOutput("stall in RESP", {63'h0, sel_stall}, 64'd0);
            end else if (sel_stall) begin
                n++;
            end
            if (c == 0) begin
                @(posedge clk);
                #1;
                valid_a   = 1'b0;
                valid_b   = 1'b0;
                req_wdata = ~wdata;
                req_addr  = addr ^ 64'h8;
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        checkOutput("response seen", {63'h0, got}, 64'd1);
        checkOutput("stall cycles", 64'(n), 64'(lat));
    endtask

    logic [63:0] wd [4];

    initial begin
        wd[0] = 64'h1111_0000_AAAA_0001;
        wd[1] = 64'h2222_0000_BBBB_0002;
        wd[2] = 64'h3333_0000_CCCC_0003;
        wd[3] = 64'h4444_0000_DDDD_0004;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset stall",     {63'h0, aif.stall},     64'd0);
        checkOutput("reset rsp_valid", {63'h0, aif.rsp_valid}, 64'd0);
        checkOutput("reset rsp_rdata", aif.rsp_rdata,          64'd0);
        checkOutput("reset rsp_fault", {63'h0, aif.rsp_fault}, 64'd0);

        // Basic quad write/read and sub-quad accesses on dut_a.
        applyStimulus(0, 1, 2'd3, 64'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 0);
        applyStimulus(0, 0, 2'd3, 64'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 0);
        applyStimulus(0, 0, 2'd0, 64'h13, 64'h0, 64'h89, 0);
        applyStimulus(0, 0, 2'd1, 64'h16, 64'h0, 64'h0123, 0);
        applyStimulus(0, 1, 2'd2, 64'h14, 64'hDEAD_BEEF, 64'h0, 0);
        applyStimulus(0, 0, 2'd3, 64'h10, 64'h0, 64'hDEAD_BEEF_89AB_CDEF, 0);
        applyStimulus(0, 1, 2'd0, 64'h11, 64'hFFFF_FF5A, 64'h0, 0);
        applyStimulus(0, 0, 2'd3, 64'h10, 64'h0, 64'hDEAD_BEEF_89AB_5AEF, 0);
        applyStimulus(0, 0, 2'd2, 64'h12, 64'h0, 64'h0, 1);
        applyStimulus(0, 0, 2'd1, 64'h11, 64'h0, 64'h0, 1);
        applyStimulus(0, 1, 2'd3, 64'h1FF8, 64'h1111_2222_3333_4444, 64'h0, 0);
        applyStimulus(0, 1, 2'd3, 64'h2000, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 1);
        applyStimulus(0, 0, 2'd3, 64'h1FF8, 64'h0, 64'h1111_2222_3333_4444, 0);

        // Reset during cycle 1 of a write must abandon it.
        applyStimulus(0, 1, 2'd3, 64'h20, 64'h5555_6666_7777_8888, 64'h0, 0);
        @(posedge clk);
        #1;
        cur_sel   = 1'b0;
        req_we    = 1'b1;
        req_size  = 2'd3;
        req_addr  = 64'h20;
        req_wdata = 64'h9999_9999_9999_9999;
        valid_a   = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("post-reset stall",     {63'h0, aif.stall},     64'd0);
        checkOutput("post-reset rsp_valid", {63'h0, aif.rsp_valid}, 64'd0);
        checkOutput("post-reset rsp_rdata", aif.rsp_rdata,          64'd0);
        checkOutput("post-reset rsp_fault", {63'h0, aif.rsp_fault}, 64'd0);
        repeat (4) @(posedge clk);
        applyStimulus(0, 0, 2'd3, 64'h20, 64'h0, 64'h5555_6666_7777_8888, 0);

        // dut_b: req_valid held high, four writes then four reads stepping by 8.
        @(posedge clk);
        #1;
        cur_sel = 1'b1;
        valid_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_we    = (k < 4);
            req_size  = 2'd3;
            req_addr  = BASE_B + 64'(8 * (k % 4));
            req_wdata = wd[k % 4];
            qb.push_back('{rdata: (k < 4) ? 64'h0 : wd[k % 4], fault: 1'b0});
            @(negedge clk);
            checkOutput("stream stall idle",     {63'h0, bif.stall},     64'd1);
            checkOutput("stream rsp_valid idle", {63'h0, bif.rsp_valid}, 64'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("stream stall resp",     {63'h0, bif.stall},     64'd0);
            checkOutput("stream rsp_valid resp", {63'h0, bif.rsp_valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        valid_b = 1'b0;

        // High BASE: offset decode and 64-bit wrap.
        applyStimulus(1, 0, 2'd3, 64'hFFFF_FFFF_FFFF_0008, 64'h0, wd[1], 0);
        applyStimulus(1, 0, 2'd3, 64'h0, 64'h0, 64'h0, 1);

        repeat (3) @(posedge clk);
        checkOutput("a pending expectations", 64'(qa.size()), 64'd0);
        checkOutput("b pending expectations", 64'(qb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
